// File: rtl/nios_v1_ocimem_pkg.sv
// Shared types and JTAG data-bus field positions for the on-chip debug memory controller.
package nios_v1_ocimem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_J_RD,
        ST_J_RD_WAIT,
        ST_J_WR,
        ST_C_RD,
        ST_C_RD_WAIT,
        ST_C_WR
    } ocimem_state_e;

    typedef enum logic {
        OP_RD,
        OP_WR
    } ocimem_op_e;

    localparam int unsigned JDO_RDREQ_BIT = 35;
    localparam int unsigned JDO_ADDR_LSB  = 17;
    localparam int unsigned JDO_WDATA_MSB = 34;
    localparam int unsigned JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios_v1_ocimem_ram.sv
// Single-port 32-bit debug RAM: synchronous read, one-cycle latency, write-first.
module nios_v1_ocimem_ram #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_q
);

    logic [31:0] r_mem [0:(1 << ADDR_W)-1];
    logic [31:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            r_q           <= i_wdata;
        end else begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/nios_v1_cpu_debug_ocimem_ctrl.sv
// Debug RAM controller: one-deep JTAG command slot arbitrated against the CPU Avalon slave, JTAG first.
// Optional OCIMEM_ROM_PROTECT_EN blocks CPU writes at or above ROM_BASE and adds sticky rom_wr_err.
module nios_v1_cpu_debug_ocimem_ctrl
    import nios_v1_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned ROM_BASE = 192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_readdatavalid,
    output logic              cpu_waitrequest,
    output logic              jtag_busy
`ifdef OCIMEM_ROM_PROTECT_EN
    ,
    output logic              rom_wr_err
`endif
);

    ocimem_state_e     r_state, w_state_nxt;
    logic              r_pend_valid;
    ocimem_op_e        r_pend_op;
    logic [ADDR_W-1:0] r_pend_addr, r_mon_a, r_cpu_addr;
    logic [31:0]       r_pend_data, r_cpu_wdata, r_mon_d, r_cpu_rdata;
    logic [ADDR_W-1:0] w_jdo_addr, w_ram_addr;
    logic [31:0]       w_ram_wdata, w_ram_q;
    logic              w_pulse, w_cpu_accept, w_ram_we, w_cpu_wr_allow, w_jtag_ram;

    assign w_pulse    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign w_jdo_addr = jdo[JDO_ADDR_LSB +: ADDR_W];

    assign cpu_waitrequest = reset | (r_state != ST_IDLE) | r_pend_valid | w_pulse;
    assign w_cpu_accept    = !cpu_waitrequest & (cpu_read | cpu_write);
    assign jtag_busy       = r_pend_valid;

    // MonAReg advances when the command is queued; the slot already holds the issue address
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_op    <= OP_RD;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
            r_mon_a      <= '0;
        end else begin
            if (r_state == ST_J_RD_WAIT || r_state == ST_J_WR) begin
                r_pend_valid <= 1'b0;
            end
            if (!r_pend_valid && w_pulse) begin
                if (take_action_ocimem_a) begin
                    r_mon_a <= w_jdo_addr;
                    if (jdo[JDO_RDREQ_BIT]) begin
                        r_pend_valid <= 1'b1;
                        r_pend_op    <= OP_RD;
                        r_pend_addr  <= w_jdo_addr;
                        r_mon_a      <= w_jdo_addr + ADDR_W'(1);
                    end
                end else if (take_no_action_ocimem_a) begin
                    r_pend_valid <= 1'b1;
                    r_pend_op    <= OP_RD;
                    r_pend_addr  <= r_mon_a;
                    r_mon_a      <= r_mon_a + ADDR_W'(1);
                end else begin
                    r_pend_valid <= 1'b1;
                    r_pend_op    <= OP_WR;
                    r_pend_addr  <= r_mon_a;
                    r_pend_data  <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
                    r_mon_a      <= r_mon_a + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cpu_addr  <= '0;
            r_cpu_wdata <= '0;
            r_mon_d     <= '0;
            r_cpu_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cpu_accept) begin
                r_cpu_addr  <= cpu_address;
                r_cpu_wdata <= cpu_writedata;
            end
            if (r_state == ST_J_RD_WAIT) r_mon_d     <= w_ram_q;
            if (r_state == ST_C_RD_WAIT) r_cpu_rdata <= w_ram_q;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (r_pend_valid) begin
                    w_state_nxt = (r_pend_op == OP_WR) ? ST_J_WR : ST_J_RD;
                end else if (w_cpu_accept) begin
                    w_state_nxt = cpu_read ? ST_C_RD : ST_C_WR;
                end
            end
            ST_J_RD:      w_state_nxt = ST_J_RD_WAIT;
            ST_C_RD:      w_state_nxt = ST_C_RD_WAIT;
            ST_J_RD_WAIT,
            ST_J_WR,
            ST_C_RD_WAIT,
            ST_C_WR:      w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // RAM q is already registered, so the wait states expose it directly and keep a copy
    assign MonDReg           = (r_state == ST_J_RD_WAIT) ? w_ram_q : r_mon_d;
    assign cpu_readdata      = (r_state == ST_C_RD_WAIT) ? w_ram_q : r_cpu_rdata;
    assign cpu_readdatavalid = (r_state == ST_C_RD_WAIT) & !reset;

    assign w_jtag_ram  = (r_state == ST_J_RD) | (r_state == ST_J_WR);
    assign w_ram_addr  = w_jtag_ram ? r_pend_addr : r_cpu_addr;
    assign w_ram_wdata = (r_state == ST_J_WR) ? r_pend_data : r_cpu_wdata;
    assign w_ram_we    = !reset & ((r_state == ST_J_WR) | ((r_state == ST_C_WR) & w_cpu_wr_allow));

`ifdef OCIMEM_ROM_PROTECT_EN
    logic w_rom_hit;
    logic w_unused;

    assign w_rom_hit      = 32'(r_cpu_addr) >= ROM_BASE;
    assign w_cpu_wr_allow = !w_rom_hit;
    assign w_unused       = ^{jdo[37:36], jdo[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_wr_err <= 1'b0;
        end else if (r_state == ST_C_WR && w_rom_hit) begin
            rom_wr_err <= 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_cpu_wr_allow = 1'b1;
    assign w_unused       = ^{jdo[37:36], jdo[2:0], ROM_BASE};
`endif

    nios_v1_ocimem_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_wdata(w_ram_wdata),
        .o_q    (w_ram_q)
    );

endmodule

// File: tb/tb_nios_v1_cpu_debug_ocimem_ctrl.sv
// Directed self-checking bench for nios_v1_cpu_debug_ocimem_ctrl (ROM checks under OCIMEM_ROM_PROTECT_EN).
module tb_nios_v1_cpu_debug_ocimem_ctrl;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned ROM_BASE = 192;

    logic              clk = 1'b0;
    logic              reset;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [31:0]       MonDReg;
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_writedata;
    logic [31:0]       cpu_readdata;
    logic              cpu_readdatavalid;
    logic              cpu_waitrequest;
    logic              jtag_busy;
`ifdef OCIMEM_ROM_PROTECT_EN
    logic              rom_wr_err;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    nios_v1_cpu_debug_ocimem_ctrl #(
        .ADDR_W  (ADDR_W),
        .ROM_BASE(ROM_BASE)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .MonDReg                (MonDReg),
        .cpu_address            (cpu_address),
        .cpu_read               (cpu_read),
        .cpu_write              (cpu_write),
        .cpu_writedata          (cpu_writedata),
        .cpu_readdata           (cpu_readdata),
        .cpu_readdatavalid      (cpu_readdatavalid),
        .cpu_waitrequest        (cpu_waitrequest),
        .jtag_busy              (jtag_busy)
`ifdef OCIMEM_ROM_PROTECT_EN
        ,
        .rom_wr_err             (rom_wr_err)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jtag_load(input logic [ADDR_W-1:0] a, input logic rd);
        jdo = '0;
        jdo[17 +: ADDR_W] = a;
        jdo[35] = rd;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_wr(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic jtag_next_rd();
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_wait_idle(input string tag);
        int unsigned n = 0;
        while (jtag_busy && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, jtag_busy, 1'b0);
    endtask

    task automatic cpu_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        int unsigned n = 0;
        cpu_address   = a;
        cpu_writedata = d;
        cpu_write     = 1'b1;
        while (cpu_waitrequest && n < 20) begin
            tick();
            n++;
        end
        check_eq("cpu_wr_accept", cpu_waitrequest, 1'b0);
        tick();
        cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [ADDR_W-1:0] a, output logic [31:0] d, output int unsigned lat);
        int unsigned n = 0;
        cpu_address = a;
        cpu_read    = 1'b1;
        while (cpu_waitrequest && n < 20) begin
            tick();
            n++;
        end
        check_eq("cpu_rd_accept", cpu_waitrequest, 1'b0);
        tick();
        cpu_read = 1'b0;
        lat = 1;
        while (!cpu_readdatavalid && lat < 10) begin
            tick();
            lat++;
        end
        d = cpu_readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int unsigned lat;
        int unsigned n;

        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        cpu_address = '0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_writedata = '0;
        tick();
        tick();

        check_eq("rst_MonDReg", MonDReg, 32'h0);
        check_eq("rst_readdata", cpu_readdata, 32'h0);
        check_eq("rst_rdvalid", cpu_readdatavalid, 1'b0);
        check_eq("rst_waitreq", cpu_waitrequest, 1'b1);
        check_eq("rst_busy", jtag_busy, 1'b0);
`ifdef OCIMEM_ROM_PROTECT_EN
        check_eq("rst_rom_wr_err", rom_wr_err, 1'b0);
`endif
        reset = 1'b0;
        #1;
        check_eq("idle_waitreq", cpu_waitrequest, 1'b0);

        cpu_wr(8'h10, 32'hDEADBEEF);
        cpu_wr(8'h11, 32'h0BADF00D);
        cpu_wr(8'h00, 32'hCAFE0000);
        cpu_wr(8'h01, 32'h01010101);
        cpu_wr(8'h30, 32'h30303030);

        // Address load with read: MonDReg valid three cycles after the pulse
        jtag_load(8'h10, 1'b1);
        check_eq("load_busy", jtag_busy, 1'b1);
        tick();
        tick();
        check_eq("load_rd_data", MonDReg, 32'hDEADBEEF);
        tick();
        check_eq("load_rd_busy_clr", jtag_busy, 1'b0);
        check_eq("load_rd_hold", MonDReg, 32'hDEADBEEF);
        jtag_next_rd();
        tick();
        tick();
        check_eq("autoinc_rd", MonDReg, 32'h0BADF00D);
        jtag_wait_idle("autoinc_idle");

        // Auto-increment writes across the top address
        jtag_load(8'hFE, 1'b0);
        check_eq("load_only_busy", jtag_busy, 1'b0);
        jtag_wr(32'h11111111);
        jtag_wait_idle("wr0_idle");
        jtag_wr(32'h22222222);
        jtag_wait_idle("wr1_idle");
        jtag_next_rd();
        tick();
        tick();
        check_eq("addr_wrap_rd", MonDReg, 32'hCAFE0000);
        jtag_wait_idle("wrap_idle");
        cpu_rd(8'hFE, rd, lat);
        check_eq("ram_FE", rd, 32'h11111111);
        cpu_rd(8'hFF, rd, lat);
        check_eq("ram_FF", rd, 32'h22222222);

        // CPU round trip
        cpu_wr(8'h20, 32'hA5A5A5A5);
        cpu_rd(8'h20, rd, lat);
        check_eq("cpu_rt_data", rd, 32'hA5A5A5A5);
        check_eq("cpu_rt_latency", lat, 32'd2);

        // JTAG priority over a same-cycle CPU read (MonAReg is now 0x01)
        tick();
        cpu_address = 8'h20;
        cpu_read = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        #1;
        check_eq("prio_wait_pulse", cpu_waitrequest, 1'b1);
        tick();
        take_no_action_ocimem_a = 1'b0;
        n = 1;
        while (cpu_waitrequest && n < 20) begin
            tick();
            n++;
        end
        check_eq("prio_wait_cycles", n, 32'd4);
        check_eq("prio_jtag_data", MonDReg, 32'h01010101);
        cpu_rd(8'h20, rd, lat);
        check_eq("prio_cpu_data", rd, 32'hA5A5A5A5);
        check_eq("prio_cpu_latency", lat, 32'd2);

        // Reset asserted during the J_WR cycle
        tick();
        jtag_load(8'h30, 1'b0);
        jtag_wr(32'hBAD0BAD0);
        tick();
        reset = 1'b1;
        tick();
        check_eq("rstmid_MonDReg", MonDReg, 32'h0);
        check_eq("rstmid_readdata", cpu_readdata, 32'h0);
        check_eq("rstmid_rdvalid", cpu_readdatavalid, 1'b0);
        check_eq("rstmid_waitreq", cpu_waitrequest, 1'b1);
        check_eq("rstmid_busy", jtag_busy, 1'b0);
        reset = 1'b0;
        tick();
        cpu_rd(8'h30, rd, lat);
        check_eq("rstmid_ram_kept", rd, 32'h30303030);
        jtag_next_rd();
        tick();
        tick();
        check_eq("rstmid_mona_zero", MonDReg, 32'hCAFE0000);
        jtag_wait_idle("rstmid_idle");

`ifdef OCIMEM_ROM_PROTECT_EN
        jtag_load(8'd200, 1'b0);
        jtag_wr(32'h55AA55AA);
        jtag_wait_idle("rom_pre_idle");
        check_eq("rom_err_before", rom_wr_err, 1'b0);
        cpu_wr(8'd200, 32'h12345678);
        tick();
        check_eq("rom_err_set", rom_wr_err, 1'b1);
        cpu_rd(8'd200, rd, lat);
        check_eq("rom_ram_kept", rd, 32'h55AA55AA);
        jtag_load(8'd200, 1'b0);
        jtag_wr(32'h77777777);
        jtag_wait_idle("rom_jtag_idle");
        cpu_rd(8'd200, rd, lat);
        check_eq("rom_jtag_wr", rd, 32'h77777777);
        check_eq("rom_err_sticky", rom_wr_err, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
